sd_crc_lanes: RTL
=================

// Module: sd_crc_lanes
// PURPOSE
//  Parametrised multi-lane SD CRC generator/checker; successor to the single-lane CRC7 block.
//  Runs LANES independent serial CRC LFSRs in lockstep: CMD line CRC7, or DAT[3:0] CRC16.
//  Adds a serialiser that shifts the accumulated CRC out MSB-first to append to the bus frame.
//  Sits between the SD bit-level TX/RX shifters and the command/data framing FSMs.
// PARAMETERS
//  CRC_W   16       CRC width in bits (7 for CMD, 16 for DAT); legal range 2..32
//  POLY    16'h1021 generator polynomial, x^CRC_W term implicit (CRC7 uses 7'h09)
//  LANES   4        number of parallel lanes (1 for CMD, 1 or 4 for DAT)
//  INIT    '0       LFSR value after reset, CLR and serialiser completion
// PORTS
//  CLK          in   1              rising-edge clock; the only clock
//  RST          in   1              asynchronous, active-low reset
//  CLR          in   1              synchronous clear of all lanes to INIT and FSM to ACCUM
//  Enable       in   1              accumulate BITVAL this cycle (ACCUM state only)
//  BITVAL       in   LANES          one serial data bit per lane
//  SHIFT_START  in   1              begin serialising the current CRC (ACCUM state only)
//  CRC          out  LANES*CRC_W    lane i CRC at [i*CRC_W +: CRC_W], registered
//  SER_OUT      out  LANES          current serial CRC bit per lane (MSB first)
//  SER_VALID    out  1              SER_OUT valid; high for exactly CRC_W cycles
//  SER_DONE     out  1              high alongside the last serial bit
//  CRC_OK       out  1              only with SD_CRC_CHECK_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (RST=0, async): all lanes = INIT, state = ACCUM, counter = 0; SER_OUT = 0,
//   SER_VALID = 0, SER_DONE = 0, CRC = {LANES{INIT}}. The same applies mid-shift.
//  Per-lane step: fb = BITVAL[i] ^ crc[CRC_W-1]; crc <= {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
//  ACCUM: the step is applied on an edge with Enable=1; crc is held otherwise. CRC reflects the
//   bit one cycle after the sampling edge (latency 1).
//  ACCUM + SHIFT_START: state -> SHIFT, counter = CRC_W-1. SHIFT_START beats Enable; the
//   Enable bit in the same cycle is dropped, not accumulated.
//  SHIFT: SER_VALID = 1; SER_OUT[i] = crc_i[CRC_W-1] (combinational from the register).
//   On each edge, crc shifts left with zero fill and counter decrements. SER_DONE = (counter==0).
//   On the edge with counter==0: lanes reload INIT and state -> ACCUM.
//   Enable and SHIFT_START are ignored in SHIFT.
//  ACCUM outputs: SER_OUT = 0, SER_VALID = 0, SER_DONE = 0.
//  CLR has priority over Enable and SHIFT_START in every state. It aborts a shift with no
//   SER_DONE, and lanes read INIT in the next cycle.
//  Back-to-back: SHIFT_START on the cycle directly after SER_DONE serialises INIT.
// CONFIGURATION
//  SD_CRC_CHECK_EN defined: adds registered output CRC_OK, which is 1 when every lane's
//   crc == 0. Use it after a receiver has accumulated data plus the received CRC bits
//   (zero-residue check). CRC_OK resets to 1 (INIT=0) and has latency 1, like CRC.
//  SD_CRC_CHECK_EN undefined: the CRC_OK port and its comparator logic are absent.
// STRUCTURE
//  sd_crc_pkg: state enum, plus constants CRC7_POLY=7'h09, CRC16_POLY=16'h1021,
//   SD_CMD_CRC_W=7, SD_DAT_CRC_W=16, SD_DAT_LANES=4.
//  Sub-module sd_crc_lane (one LFSR with load/step/shift) is instantiated LANES times
//   by a generate loop. The FSM and counter ($clog2(CRC_W) bits) live in the top level.
// TESTING
//  1 CRC_W=7, POLY=7'h09, LANES=1: feed 0x40_00000000 (40 bits) -> CRC=7'h4A.
//    Then SHIFT_START -> SER_OUT = 1,0,0,1,0,1,0 over 7 cycles, SER_DONE on the 7th.
//  2 Same config: feed 0x48_000001AA -> CRC=7'h43.
//    Enable held low for random gaps mid-frame -> same result.
//  3 CRC_W=16, POLY=16'h1021, LANES=4, INIT=0: ASCII "123456789" on lane 0 -> 16'h31C3.
//    Lanes 1..3 fed all-ones over 512 bytes -> 16'h7FA1; lane independence checked.
//  4 RST asserted at shift bit 5: all outputs 0 and CRC=INIT immediately, with no SER_DONE.
//    CLR at shift bit 5 -> INIT next cycle, SER_VALID low.
//  5 SHIFT_START and Enable together in ACCUM: bit dropped, CRC unchanged at shift start.
//    SHIFT_START the cycle after SER_DONE -> 16 zero bits shifted out.
//  6 SD_CRC_CHECK_EN: accumulate test-3 data, then its CRC bits -> CRC_OK=1.
//    Flip one bit -> CRC_OK=0.

Source files
------------

// File: rtl/sd_crc_pkg.sv
// Shared types and constants for the SD CRC lane blocks: FSM state encoding
// plus the standard SD CMD/DAT CRC widths and polynomials.
package sd_crc_pkg;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_SHIFT = 1'b1
  } crc_state_e;

  localparam logic [6:0]  CRC7_POLY    = 7'h09;
  localparam logic [15:0] CRC16_POLY   = 16'h1021;
  localparam int unsigned SD_CMD_CRC_W = 7;
  localparam int unsigned SD_DAT_CRC_W = 16;
  localparam int unsigned SD_DAT_LANES = 4;

endpackage

// File: rtl/sd_crc_lane.sv
// One serial CRC LFSR with load-INIT, accumulate-step and zero-fill shift.
// With SD_CRC_CHECK_EN defined it also exports its next-state value.
module sd_crc_lane
  import sd_crc_pkg::*;
#(
  parameter int unsigned      CRC_W = SD_DAT_CRC_W,
  parameter logic [CRC_W-1:0] POLY  = CRC16_POLY,
  parameter logic [CRC_W-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_init,
  input  logic             step_en,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc_o
`ifdef SD_CRC_CHECK_EN
  ,
  output logic [CRC_W-1:0] crc_next_o
`endif
);

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;
  logic [CRC_W-1:0] shifted;
  logic             fb;

  always_comb begin
    shifted = {crc_q[CRC_W-2:0], 1'b0};
    fb      = bit_in ^ crc_q[CRC_W-1];
    crc_d   = crc_q;
    // Load wins over shift, shift wins over step; the top keeps them exclusive anyway.
    if (load_init) begin
      crc_d = INIT;
    end else if (shift_en) begin
      crc_d = shifted;
    end else if (step_en) begin
      crc_d = shifted ^ (fb ? POLY : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

`ifdef SD_CRC_CHECK_EN
  assign crc_next_o = crc_d;
`endif

endmodule

// File: rtl/sd_crc_lanes.sv
// Multi-lane SD CRC7/CRC16 generator/checker with MSB-first serialiser.
// Optional zero-residue flag CRC_OK is built only when SD_CRC_CHECK_EN is defined.
module sd_crc_lanes
  import sd_crc_pkg::*;
#(
  parameter int unsigned      CRC_W = SD_DAT_CRC_W,
  parameter logic [CRC_W-1:0] POLY  = CRC16_POLY,
  parameter int unsigned      LANES = SD_DAT_LANES,
  parameter logic [CRC_W-1:0] INIT  = '0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CLR,
  input  logic                   Enable,
  input  logic [LANES-1:0]       BITVAL,
  input  logic                   SHIFT_START,
  output logic [LANES*CRC_W-1:0] CRC,
  output logic [LANES-1:0]       SER_OUT,
  output logic                   SER_VALID,
  output logic                   SER_DONE
`ifdef SD_CRC_CHECK_EN
  ,
  output logic                   CRC_OK
`endif
);

  localparam int unsigned CNT_W = $clog2(CRC_W);

  crc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lane_load, lane_step, lane_shift;
  logic [CRC_W-1:0] lane_crc [LANES];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_load  = 1'b0;
    lane_step  = 1'b0;
    lane_shift = 1'b0;
    if (CLR) begin
      state_d   = ST_ACCUM;
      cnt_d     = '0;
      lane_load = 1'b1;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          // A start request drops any bit offered in the same cycle.
          if (SHIFT_START) begin
            state_d = ST_SHIFT;
            cnt_d   = CNT_W'(CRC_W - 1);
          end else if (Enable) begin
            lane_step = 1'b1;
          end
        end
        ST_SHIFT: begin
          if (cnt_q == '0) begin
            lane_load = 1'b1;
            state_d   = ST_ACCUM;
          end else begin
            lane_shift = 1'b1;
            cnt_d      = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d   = ST_ACCUM;
          cnt_d     = '0;
          lane_load = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_ACCUM;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign SER_VALID = (state_q == ST_SHIFT);
  assign SER_DONE  = (state_q == ST_SHIFT) && (cnt_q == '0);

`ifdef SD_CRC_CHECK_EN
  logic [CRC_W-1:0] lane_next [LANES];
  logic [LANES-1:0] lane_zero;
  logic             crc_ok_q, crc_ok_d;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      sd_crc_lane #(
        .CRC_W(CRC_W),
        .POLY (POLY),
        .INIT (INIT)
      ) u_lane (
        .clk       (CLK),
        .rst_n     (RST),
        .load_init (lane_load),
        .step_en   (lane_step),
        .shift_en  (lane_shift),
        .bit_in    (BITVAL[gi]),
        .crc_o     (lane_crc[gi])
`ifdef SD_CRC_CHECK_EN
        ,
        .crc_next_o(lane_next[gi])
`endif
      );

      assign CRC[gi*CRC_W +: CRC_W] = lane_crc[gi];
      assign SER_OUT[gi]            = SER_VALID & lane_crc[gi][CRC_W-1];

`ifdef SD_CRC_CHECK_EN
      assign lane_zero[gi] = (lane_next[gi] == '0);
`endif
    end
  endgenerate

`ifdef SD_CRC_CHECK_EN
  // Registered from the lanes' next state so it tracks CRC with the same latency.
  assign crc_ok_d = &lane_zero;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      crc_ok_q <= (INIT == '0);
    end else begin
      crc_ok_q <= crc_ok_d;
    end
  end

  assign CRC_OK = crc_ok_q;
`endif

endmodule
